// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package btb_pkg;

    // Widest counter the helpers handle; callers slice down to CNT_W.
    localparam int CNT_MAX_W = 16;
    typedef logic [CNT_MAX_W-1:0] cnt_t;

    function automatic cnt_t cnt_max(input int w);
        return cnt_t'((32'd1 << w) - 32'd1);
    endfunction

    // Saturating increment, stops at all-ones for a w-bit counter.
    function automatic cnt_t sat_inc(input cnt_t c, input int w);
        return (c >= cnt_max(w)) ? cnt_max(w) : c + cnt_t'(1);
    endfunction

    // Saturating decrement, stops at zero.
    function automatic cnt_t sat_dec(input cnt_t c, input int w);
        return (c == '0) ? '0 : c - cnt_t'(1);
    endfunction

    // Weakly-taken value: only the MSB of a w-bit counter set.
    function automatic cnt_t CNT_WEAK_T(input int w);
        return cnt_t'(32'd1 << (w - 1));
    endfunction

    // Entry layout, LSB first: valid | tag | target[XLEN-1:2] | cnt | jmp.
    function automatic int off_valid();
        return 0;
    endfunction

    function automatic int off_tag();
        return 1;
    endfunction

    function automatic int off_target(input int tag_w);
        return 1 + tag_w;
    endfunction

    function automatic int off_cnt(input int xlen, input int tag_w);
        return 1 + tag_w + (xlen - 2);
    endfunction

    function automatic int off_jmp(input int xlen, input int tag_w, input int cnt_w);
        return off_cnt(xlen, tag_w) + cnt_w;
    endfunction

    function automatic int entry_w(input int xlen, input int tag_w, input int cnt_w);
        return off_jmp(xlen, tag_w, cnt_w) + 1;
    endfunction

    // Replacement logic only exists for these associativities.
    function automatic bit ways_legal(input int ways);
        return (ways == 1) || (ways == 2) || (ways == 4);
    endfunction

endpackage

// File: rtl/btb_plru.sv
// Per-set pseudo-LRU replacement bits; victim lookup for one queried set.
// Latency: victim is combinational; touches and flush commit on the next clk edge.
// Backpressure: none, a touch is accepted every cycle.
module btb_plru #(
    parameter  int WAYS  = 2,
    parameter  int SETS  = 32,
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             touch_valid,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic [SET_W-1:0] query_set,
    output logic [WAY_W-1:0] victim_way
);

    generate
        if (WAYS == 4) begin : g_tree
            // bit0 root (0 = victim in ways 0/1), bit1 picks within 0/1, bit2 within 2/3
            logic [2:0] tree [SETS];

            // Walk the tree of the queried set towards the victim
            always_comb begin
                victim_way = tree[query_set][0] ? {1'b1, tree[query_set][2]}
                                                : {1'b0, tree[query_set][1]};
            end

            // Point every bit on the touched path away from the touched way
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) tree[s] <= '0;
                end else if (flush) begin
                    for (int s = 0; s < SETS; s++) tree[s] <= '0;
                end else if (touch_valid) begin
                    tree[touch_set][0] <= ~touch_way[1];
                    if (touch_way[1]) tree[touch_set][2] <= ~touch_way[0];
                    else              tree[touch_set][1] <= ~touch_way[0];
                end
            end
        end else if (WAYS == 2) begin : g_bit
            // One bit per set naming the victim way directly
            logic bits [SETS];

            // Victim is the stored bit
            always_comb begin
                victim_way = bits[query_set];
            end

            // Touching a way makes the other one the victim
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) bits[s] <= 1'b0;
                end else if (flush) begin
                    for (int s = 0; s < SETS; s++) bits[s] <= 1'b0;
                end else if (touch_valid) begin
                    bits[touch_set] <= ~touch_way[0];
                end
            end
        end else begin : g_none
            // Direct-mapped: the only way is always the victim
            logic unused_plru;
            assign unused_plru = ^{clk, rst_n, flush, touch_valid, touch_set, touch_way, query_set};
            assign victim_way  = '0;
        end
    endgenerate

endmodule

// File: rtl/btb_sa.sv
// Set-associative BTB: combinational prediction from pc_if, training writes from MEM.
// Latency: prediction zero-cycle; updates visible the cycle after they are presented.
// Backpressure: none, one update accepted per cycle; flush drops a same-cycle update.
module btb_sa
    import btb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int WAYS    = 2,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_if,
    output logic            predict_hit,
    output logic            predict_taken,
    output logic [XLEN-1:0] predicted_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_is_jump
);

    localparam int SETS    = ENTRIES / WAYS;
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = XLEN - IDX_W - 2;
    localparam int TGT_W   = XLEN - 2;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int O_VLD   = off_valid();
    localparam int O_TAG   = off_tag();
    localparam int O_TGT   = off_target(TAG_W);
    localparam int O_CNT   = off_cnt(XLEN, TAG_W);
    localparam int O_JMP   = off_jmp(XLEN, TAG_W, CNT_W);
    localparam int ENT_W   = entry_w(XLEN, TAG_W, CNT_W);

    generate
        if (!ways_legal(WAYS) || CNT_W < 2 || CNT_W > CNT_MAX_W) begin : g_bad_cfg
            $error("btb_sa: unsupported WAYS or CNT_W");
        end
    endgenerate

    logic [ENT_W-1:0] mem [SETS][WAYS];

    logic [IDX_W-1:0] p_idx, u_idx;
    logic [TAG_W-1:0] p_tag, u_tag;
    logic             p_hit, u_hit, inv_found;
    logic [WAY_W-1:0] p_way, u_way, inv_way, plru_vic, wr_way;
    logic [ENT_W-1:0] p_ent, u_old, u_new;
    logic             wr_en;
    cnt_t             cnt_nxt;

    assign p_idx = pc_if[IDX_W+1:2];
    assign p_tag = pc_if[XLEN-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX_W+2];

    // Prediction lookup; scanning downwards lets the lowest matching way win
    always_comb begin
        p_hit = 1'b0;
        p_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mem[p_idx][w][O_VLD] && mem[p_idx][w][O_TAG +: TAG_W] == p_tag) begin
                p_hit = 1'b1;
                p_way = WAY_W'(w);
            end
        end
    end

    assign p_ent            = mem[p_idx][p_way];
    assign predict_hit      = p_hit;
    assign predict_taken    = p_hit & (p_ent[O_JMP] | p_ent[O_CNT + CNT_W - 1]);
    assign predicted_target = predict_taken ? {p_ent[O_TGT +: TGT_W], 2'b00} : '0;

    // Update lookup: matching way, plus lowest invalid way for allocation
    always_comb begin
        u_hit     = 1'b0;
        u_way     = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mem[u_idx][w][O_VLD] && mem[u_idx][w][O_TAG +: TAG_W] == u_tag) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!mem[u_idx][w][O_VLD]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign wr_way = u_hit ? u_way : (inv_found ? inv_way : plru_vic);
    assign wr_en  = upd_valid & (u_hit | upd_taken | upd_is_jump);
    assign u_old  = mem[u_idx][wr_way];

    // New entry contents: train the existing entry on a hit, fresh weakly-taken one otherwise
    always_comb begin
        u_new   = u_old;
        cnt_nxt = '0;
        if (u_hit) begin
            cnt_nxt = upd_taken ? sat_inc(cnt_t'(u_old[O_CNT +: CNT_W]), CNT_W)
                                : sat_dec(cnt_t'(u_old[O_CNT +: CNT_W]), CNT_W);
            u_new[O_CNT +: CNT_W] = cnt_nxt[CNT_W-1:0];
            if (upd_taken) u_new[O_TGT +: TGT_W] = upd_target[XLEN-1:2];
            u_new[O_JMP] = upd_is_jump;
        end else begin
            cnt_nxt               = CNT_WEAK_T(CNT_W);
            u_new                 = '0;
            u_new[O_VLD]          = 1'b1;
            u_new[O_TAG +: TAG_W] = u_tag;
            u_new[O_TGT +: TGT_W] = upd_target[XLEN-1:2];
            u_new[O_CNT +: CNT_W] = cnt_nxt[CNT_W-1:0];
            u_new[O_JMP]          = upd_is_jump;
        end
    end

    // Entry array: flush invalidates everything and swallows any same-cycle update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    mem[s][w] <= '0;
        end else if (flush) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    mem[s][w][O_VLD] <= 1'b0;
        end else if (wr_en) begin
            mem[u_idx][wr_way] <= u_new;
        end
    end

    btb_plru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .touch_valid (wr_en),
        .touch_set   (u_idx),
        .touch_way   (wr_way),
        .query_set   (u_idx),
        .victim_way  (plru_vic)
    );

endmodule

// File: tb/tb_btb_sa.sv
// Self-checking bench for btb_sa (XLEN=32, ENTRIES=64, WAYS=2, CNT_W=2).
// Latency: checks prediction before each edge against a pre-edge reference model.
// Backpressure: n/a.
module tb_btb_sa;

    localparam int SETS  = 32;
    localparam int NWAY  = 2;
    localparam int IDX_W = 5;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] pc_if;
    logic        predict_hit;
    logic        predict_taken;
    logic [31:0] predicted_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_jump;

    int total = 0;
    int bad   = 0;

    btb_sa #(.XLEN(32), .ENTRIES(64), .WAYS(2), .CNT_W(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .pc_if            (pc_if),
        .predict_hit      (predict_hit),
        .predict_taken    (predict_taken),
        .predicted_target (predicted_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .upd_is_jump      (upd_is_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each set is a list of slots plus the most recently used slot.
    typedef struct {
        bit          v;
        logic [31:0] pc;      // full PC with low bits cleared, compared by tag+index
        logic [31:0] tgt;
        int          cnt;
        bit          jmp;
    } slot_t;

    slot_t m [SETS][NWAY];
    int    mru [SETS];

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic logic [31:0] key_of(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            mru[s] = NWAY - 1;
            for (int w = 0; w < NWAY; w++) m[s][w] = '{v: 0, pc: 0, tgt: 0, cnt: 0, jmp: 0};
        end
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) begin
            mru[s] = NWAY - 1;
            for (int w = 0; w < NWAY; w++) m[s][w].v = 0;
        end
    endtask

    function automatic int model_find(input logic [31:0] pc);
        int s = set_of(pc);
        for (int w = 0; w < NWAY; w++)
            if (m[s][w].v && m[s][w].pc == key_of(pc)) return w;
        return -1;
    endfunction

    task automatic model_pred(input logic [31:0] pc, output logic [31:0] h,
                              output logic [31:0] t, output logic [31:0] tg);
        int w = model_find(pc);
        int s = set_of(pc);
        h = 0; t = 0; tg = 0;
        if (w >= 0) begin
            h = 1;
            if (m[s][w].jmp || m[s][w].cnt >= 2) begin
                t  = 1;
                tg = m[s][w].tgt & ~32'h3;
            end
        end
    endtask

    task automatic model_upd(input logic [31:0] pc, input logic [31:0] tgt,
                             input bit tk, input bit jp);
        int s = set_of(pc);
        int w = model_find(pc);
        if (w >= 0) begin
            m[s][w].cnt = tk ? ((m[s][w].cnt < 3) ? m[s][w].cnt + 1 : 3)
                             : ((m[s][w].cnt > 0) ? m[s][w].cnt - 1 : 0);
            if (tk) m[s][w].tgt = tgt;
            m[s][w].jmp = jp;
            mru[s] = w;
        end else if (tk || jp) begin
            w = -1;
            for (int i = 0; i < NWAY; i++) if (w < 0 && !m[s][i].v) w = i;
            if (w < 0) w = 1 - mru[s];
            m[s][w] = '{v: 1, pc: key_of(pc), tgt: tgt, cnt: 2, jmp: jp};
            mru[s] = w;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic check_pred(input string nm);
        logic [31:0] eh, et, eg;
        model_pred(pc_if, eh, et, eg);
        chk({nm, "_hit"},    {31'd0, predict_hit},   eh);
        chk({nm, "_taken"},  {31'd0, predict_taken}, et);
        chk({nm, "_target"}, predicted_target,       eg);
    endtask

    // One cycle: inputs were set just after an edge; check, clock, mirror the edge in the model.
    task automatic step(input string nm);
        #1;
        check_pred(nm);
        @(posedge clk);
        if (!rst_n)          model_reset();
        else if (flush)      model_flush();
        else if (upd_valid)  model_upd(upd_pc, upd_target, upd_taken, upd_is_jump);
        #1;
    endtask

    task automatic set_upd(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                           input bit tk, input bit jp);
        upd_valid = v; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_is_jump = jp;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; pc_if = 32'h100;
        set_upd(0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_pred("in_reset");
        chk("in_reset_hit_const", {31'd0, predict_hit}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cold miss, then allocate 0x100 -> 0x200
        pc_if = 32'h100; set_upd(1, 32'h100, 32'h200, 1, 0);
        step("cold_miss");
        set_upd(0, 0, 0, 0, 0);
        step("first_hit");
        chk("first_hit_target_const", predicted_target, 32'h200);

        // Drive counter to zero and past it
        for (int i = 0; i < 3; i++) begin
            set_upd(1, 32'h100, 32'h999, 0, 0);
            step("nt_train");
        end
        set_upd(0, 0, 0, 0, 0);
        step("cnt_floor");
        chk("cnt_floor_taken_const", {31'd0, predict_taken}, 32'd0);
        // One taken from a floored counter must still predict not-taken
        set_upd(1, 32'h100, 32'h204, 1, 0);
        step("cnt_up1");
        set_upd(0, 0, 0, 0, 0);
        step("cnt_one");
        set_upd(1, 32'h100, 32'h208, 1, 0);
        step("cnt_up2");

        // Conflict set 0: 0x200 allocates, 0x100 touched, 0x300 evicts 0x200
        set_upd(1, 32'h200, 32'h1234, 1, 0); pc_if = 32'h200;
        step("alloc_200");
        set_upd(1, 32'h100, 32'h300, 1, 0); pc_if = 32'h100;
        step("touch_100");
        set_upd(1, 32'h300, 32'h5678, 1, 0); pc_if = 32'h300;
        step("alloc_300");
        set_upd(0, 0, 0, 0, 0);
        pc_if = 32'h200; step("evicted_200");
        chk("evicted_200_hit_const", {31'd0, predict_hit}, 32'd0);
        pc_if = 32'h100; step("kept_100");
        pc_if = 32'h300; step("kept_300");

        // Jump stays taken through not-taken training, target unchanged
        set_upd(1, 32'h400, 32'h4440, 0, 1); pc_if = 32'h400;
        step("jmp_alloc");
        for (int i = 0; i < 3; i++) begin
            set_upd(1, 32'h400, 32'h7770, 0, 1);
            step("jmp_nt");
        end
        set_upd(0, 0, 0, 0, 0);
        step("jmp_hold");
        chk("jmp_hold_target_const", predicted_target, 32'h4440);

        // Flush with a same-cycle update: everything misses afterwards
        set_upd(1, 32'h500, 32'h5500, 1, 0); flush = 1'b1;
        step("flush_cycle");
        flush = 1'b0; set_upd(0, 0, 0, 0, 0);
        pc_if = 32'h500; step("post_flush_500");
        chk("post_flush_500_const", {31'd0, predict_hit}, 32'd0);
        pc_if = 32'h400; step("post_flush_400");

        // Reset asserted mid-update
        set_upd(1, 32'h600, 32'h6600, 1, 0); pc_if = 32'h600;
        step("pre_rst_alloc");
        set_upd(1, 32'h600, 32'h6604, 1, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_pred("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1; set_upd(0, 0, 0, 0, 0);
        step("post_rst_600");
        chk("post_rst_600_const", {31'd0, predict_hit}, 32'd0);

        // Random traffic over a few conflicting sets and tags
        for (int i = 0; i < 400; i++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2);
            set_upd($urandom_range(0, 3) != 0, p, $urandom,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 49) == 0);
            pc_if = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2);
            step("rand");
        end
        flush = 1'b0; set_upd(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
